// File: rtl/pll_lock_supervisor.sv
// Runs on refclk. Holds the PLL and its output-domain logic in reset until lock has
// been stable long enough, retries the PLL reset when lock times out, and recovers when lock is lost.
module pll_lock_supervisor #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2,
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_count,
  output logic [7:0]    lock_loss_count
);

  // state     | meaning
  // RESET_PLL | pll_rst pulse of PLL_RST_CYCLES
  // WAIT_LOCK | PLL released, waiting for lk, with timeout
  // STABILIZE | lk seen, waiting until it has held for LOCK_STABLE_CYCLES
  // RUN       | downstream logic released
  // FAULT     | retries exhausted; left only through rst
  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam int MAX_AB = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                          LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_C  = (MAX_AB > PLL_RST_CYCLES) ? MAX_AB : PLL_RST_CYCLES;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, sys_rst_q, ready_q, fault_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lk = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      S_RESET_PLL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        cnt_d = cnt_q + CW'(1);
        // Lock wins over a coincident timeout.
        if (lk) begin
          state_d = S_STABILIZE;
        end else if (cnt_q == TMO_LAST) begin
          if (retry_q == RTY_MAX) begin
            state_d = S_FAULT;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = S_RESET_PLL;
          end
        end
      end
      S_STABILIZE: begin
        cnt_d = cnt_q + CW'(1);
        if (!lk)                  state_d = S_WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lk) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          retry_d = '0;
          state_d = S_RESET_PLL;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RESET_PLL;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      sys_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed-vector bench for pll_lock_supervisor with small sim parameters:
// a table of {rst, pll_locked, cycles, expected outputs} rows plus hand sequences.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_vec  = 0;
  int n_miss = 0;

  pll_lock_supervisor #(
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(64),
    .PLL_RST_CYCLES     (4),
    .MAX_RETRIES        (2),
    .SYNC_STAGES        (2)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic       rst;
    logic       lock;
    int         ticks;
    logic       e_pll;
    logic       e_sys;
    logic       e_rdy;
    logic       e_flt;
    logic [1:0] e_retry;
    logic [7:0] e_loss;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic l, input int t, input logic p,
                     input logic s, input logic rd, input logic f,
                     input logic [1:0] rc, input logic [7:0] lc);
    vec_t v;
    v.rst = r; v.lock = l; v.ticks = t; v.e_pll = p; v.e_sys = s;
    v.e_rdy = rd; v.e_flt = f; v.e_retry = rc; v.e_loss = lc;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input logic val, input int budget, input string name);
    int n = 0;
    while (ready !== val && n < budget) begin
      tick();
      n++;
    end
    n_vec++;
    if (ready !== val) begin
      n_miss++;
      $display("FAIL %s: ready=%b required %b within %0d cycles", name, ready, val, budget);
    end
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst        = tbl[i].rst;
      pll_locked = tbl[i].lock;
      repeat (tbl[i].ticks) tick();
      check($sformatf("row%0d pll_rst", i),     pll_rst,         tbl[i].e_pll);
      check($sformatf("row%0d sys_rst", i),     sys_rst,         tbl[i].e_sys);
      check($sformatf("row%0d ready", i),       ready,           tbl[i].e_rdy);
      check($sformatf("row%0d fault", i),       fault,           tbl[i].e_flt);
      check($sformatf("row%0d retry_count", i), retry_count,     tbl[i].e_retry);
      check($sformatf("row%0d loss_count", i),  lock_loss_count, tbl[i].e_loss);
    end
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;

    //  rst lock ticks pll sys rdy flt retry loss
    // bring-up: 4-cycle pll_rst pulse, lock raised 10 cycles after release
    add(1, 0,  1, 1, 1, 0, 0, 0, 0);   // 0
    add(0, 0,  3, 1, 1, 0, 0, 0, 0);
    add(0, 0,  1, 0, 1, 0, 0, 0, 0);
    add(0, 0,  6, 0, 1, 0, 0, 0, 0);
    add(0, 1, 10, 0, 1, 0, 0, 0, 0);
    add(0, 1,  1, 0, 0, 1, 0, 0, 0);   // 5: ready on 11th edge
    // loss in RUN: ready drops on 3rd edge, then 4-cycle pulse, then re-lock
    add(0, 0,  2, 0, 0, 1, 0, 0, 0);
    add(0, 0,  1, 1, 1, 0, 0, 0, 1);
    add(0, 0,  3, 1, 1, 0, 0, 0, 1);
    add(0, 0,  1, 0, 1, 0, 0, 0, 1);
    add(0, 1, 10, 0, 1, 0, 0, 0, 1);   // 10
    add(0, 1,  1, 0, 0, 1, 0, 0, 1);
    // second loss, then a one-cycle glitch at stabilize count 5
    add(0, 0,  3, 1, 1, 0, 0, 0, 2);
    add(0, 0,  4, 0, 1, 0, 0, 0, 2);
    add(0, 1,  8, 0, 1, 0, 0, 0, 2);
    add(0, 0,  1, 0, 1, 0, 0, 0, 2);   // 15
    add(0, 1,  2, 0, 1, 0, 0, 0, 2);
    add(0, 1,  8, 0, 1, 0, 0, 0, 2);
    add(0, 1,  1, 0, 0, 1, 0, 0, 2);   // 18: 11 edges after re-lock sample
    // never lock: three pulses, fault at edge 204
    add(1, 0,  1, 1, 1, 0, 0, 0, 0);   // 19
    add(0, 0,  3, 1, 1, 0, 0, 0, 0);   // 20
    add(0, 0,  1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 63, 0, 1, 0, 0, 0, 0);
    add(0, 0,  1, 1, 1, 0, 0, 1, 0);
    add(0, 0,  3, 1, 1, 0, 0, 1, 0);
    add(0, 0,  1, 0, 1, 0, 0, 1, 0);   // 25
    add(0, 0, 63, 0, 1, 0, 0, 1, 0);
    add(0, 0,  1, 1, 1, 0, 0, 2, 0);
    add(0, 0,  3, 1, 1, 0, 0, 2, 0);
    add(0, 0,  1, 0, 1, 0, 0, 2, 0);
    add(0, 0, 63, 0, 1, 0, 0, 2, 0);   // 30
    add(0, 0,  1, 1, 1, 0, 1, 2, 0);
    add(0, 1, 30, 1, 1, 0, 1, 2, 0);   // 32: lock ignored in FAULT

    apply_rows(0, 18);

    // async reset while in STABILIZE, checked before the next edge
    pll_locked = 1'b0;
    repeat (3) tick();
    check("pre-reset loss_count", lock_loss_count, 8'd3);
    pll_locked = 1'b1;
    repeat (7) tick();
    check("pre-reset ready", ready, 1'b0);
    @(negedge refclk);
    rst = 1'b1;
    #1;
    check("async pll_rst",     pll_rst,         1'b1);
    check("async sys_rst",     sys_rst,         1'b1);
    check("async ready",       ready,           1'b0);
    check("async fault",       fault,           1'b0);
    check("async retry_count", retry_count,     2'd0);
    check("async loss_count",  lock_loss_count, 8'd0);

    apply_rows(19, 32);

    // saturation of lock_loss_count over 257 losses
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pll_locked = 1'b1;
    wait_ready(1'b1, 60, "sat initial lock");
    for (int i = 0; i < 257; i++) begin
      pll_locked = 1'b0;
      wait_ready(1'b0, 10, $sformatf("sat loss %0d", i));
      check($sformatf("sat loss_count %0d", i), lock_loss_count,
            (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      pll_locked = 1'b1;
      wait_ready(1'b1, 40, $sformatf("sat relock %0d", i));
    end
    check("sat final loss_count", lock_loss_count, 8'd255);
    check("sat final sys_rst",    sys_rst,         1'b0);
    check("sat final retry",      retry_count,     2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
